traffic_countdown_module: RTL and testbench
===========================================

Name: traffic_countdown_module

Overview:
- Traffic-light phase controller and BCD countdown generator for a two-direction intersection (NS, EW).
- Sequences the green, yellow and red phases and drives the lamp outputs.
- Produces the remaining-seconds count as two BCD digits, Ten_Data and One_Data.
- Sits directly upstream of smg_encoder_module; its digit outputs connect straight to that block's Ten_Data/One_Data inputs.

Parameters:
- CNT_1S, 50_000_000: CLK cycles per 1 s tick. Legal range ≥2.
- GREEN_TIME, 30: green phase length in seconds. Legal range 1..99.
- YELLOW_TIME, 3: yellow phase length in seconds. Legal range 1..99.

Ports:
- CLK  input  1  system clock
- RSTn  input  1  reset, asynchronous, active-low
- Pause  input  1  high = freeze prescaler, countdown and phase
- Ten_Data  output  4  BCD tens digit of remaining seconds, 0..9
- One_Data  output  4  BCD ones digit of remaining seconds, 0..9
- NS_Light  output  3  {R,Y,G} NS lamps, one-hot, active-high
- EW_Light  output  3  {R,Y,G} EW lamps, one-hot, active-high
- Tick_1s  output  1  one-CLK pulse per elapsed second

Behaviour:
- Reset (RSTn low, asynchronous, effective at any point mid-operation):
  - state=NS_GREEN, prescaler=0, Tick_1s=0.
  - Ten_Data=GREEN_TIME/10, One_Data=GREEN_TIME%10.
  - NS_Light=3'b001, EW_Light=3'b100.
- Prescaler:
  - Counts 0..CNT_1S-1 and wraps to 0.
  - Tick_1s is a registered pulse, high for the single cycle following the cycle in which prescaler==CNT_1S-1.
  - First tick after reset release arrives on cycle CNT_1S.
- Pause high: prescaler holds its value, no tick is generated, and digits, state and lights hold.
  - On Pause low, counting resumes from the held prescaler value; no second is lost or repeated.
- FSM states, in order NS_GREEN -> NS_YELLOW -> EW_GREEN -> EW_YELLOW -> NS_GREEN.
  - Lights per state (NS_Light / EW_Light):
    - NS_GREEN: 001 / 100
    - NS_YELLOW: 010 / 100
    - EW_GREEN: 100 / 001
    - EW_YELLOW: 100 / 010
  - Red time per direction is therefore GREEN_TIME+YELLOW_TIME.
- Countdown, evaluated in the cycle Tick_1s is high; updates are visible the next cycle:
  - Display value 01: advance to the next state and load that phase's length into the digits (GREEN_TIME for *_GREEN, YELLOW_TIME for *_YELLOW). The digits never show 00.
  - Ones digit 0 (value >01): One_Data=9, Ten_Data=Ten_Data-1.
  - Otherwise: One_Data=One_Data-1.
- Phase duration: each phase shows T, T-1, …, 1 and lasts exactly T*CNT_1S cycles.
- Lights and digits change in the same clock edge at a phase change.
- Output validity:
  - Digits are always valid BCD (0..9); an illegal value is never produced.
  - Lights are always one-hot per direction.
  - Both directions are never simultaneously non-red.
- Phase length 1 s: the phase shows 01 for one second, then advances.
- All outputs are registered; there are no combinational paths from inputs to outputs.

Test Plan:
- CNT_1S=4, GREEN=12, YELLOW=3, reset released -> digits 1,2 with NS=001/EW=100; Tick_1s high at cycles 4, 8, …; after 3 ticks the digits are 0,9 (tens borrow).
- Same configuration, run 12 ticks -> the 12th tick gives NS_YELLOW, NS=010, digits 0,3; after 3 more ticks EW_GREEN, EW=001, NS=100, digits 1,2.
- Full cycle of 30 ticks -> back in NS_GREEN with digits 1,2.
  - Check every cycle that no cycle has both directions non-red and that digits never show 00 or >9.
- Pause high for 20 cycles mid-second (prescaler=2) -> digits, lights and prescaler frozen; after release the next tick occurs 2 cycles later.
- YELLOW=1 -> yellow shows 0,1 for exactly 4 cycles and then switches.
  - GREEN=99 -> digits 9,9 decrementing to 9,8 and later 8,9.
- RSTn asserted asynchronously mid-EW_YELLOW (between clock edges) -> outputs return to reset values immediately; the first tick follows CNT_1S cycles after release.

Source files
------------

// File: rtl/traffic_countdown_module.sv
// Two-direction traffic-light phase controller with a 1 s prescaler and a
// two-digit BCD countdown of the seconds remaining in the current phase.
module traffic_countdown_module #(
    parameter int CNT_1S      = 50_000_000,
    parameter int GREEN_TIME  = 30,
    parameter int YELLOW_TIME = 3
) (
    input  logic       CLK,
    input  logic       RSTn,
    input  logic       Pause,
    output logic [3:0] Ten_Data,
    output logic [3:0] One_Data,
    output logic [2:0] NS_Light,
    output logic [2:0] EW_Light,
    output logic       Tick_1s
);

    localparam int            PW       = (CNT_1S > 2) ? $clog2(CNT_1S) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(CNT_1S - 1);
    localparam logic [3:0]    G_TEN    = 4'(GREEN_TIME / 10);
    localparam logic [3:0]    G_ONE    = 4'(GREEN_TIME % 10);
    localparam logic [3:0]    Y_TEN    = 4'(YELLOW_TIME / 10);
    localparam logic [3:0]    Y_ONE    = 4'(YELLOW_TIME % 10);

    localparam logic [2:0] LAMP_R = 3'b100;
    localparam logic [2:0] LAMP_Y = 3'b010;
    localparam logic [2:0] LAMP_G = 3'b001;

    typedef enum logic [1:0] {
        NS_GREEN  = 2'd0,
        NS_YELLOW = 2'd1,
        EW_GREEN  = 2'd2,
        EW_YELLOW = 2'd3
    } state_t;

    state_t        state, state_nxt;
    logic [PW-1:0] pre;
    logic [3:0]    ten_nxt, one_nxt;
    logic [2:0]    ns_nxt, ew_nxt;

    // Prescaler and tick: a paused prescaler holds, so the second in progress resumes intact.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            pre     <= '0;
            Tick_1s <= 1'b0;
        end else if (Pause) begin
            Tick_1s <= 1'b0;
        end else begin
            Tick_1s <= (pre == PRE_LAST);
            pre     <= (pre == PRE_LAST) ? '0 : pre + PW'(1);
        end
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state    <= NS_GREEN;
            Ten_Data <= G_TEN;
            One_Data <= G_ONE;
            NS_Light <= LAMP_G;
            EW_Light <= LAMP_R;
        end else begin
            state    <= state_nxt;
            Ten_Data <= ten_nxt;
            One_Data <= one_nxt;
            NS_Light <= ns_nxt;
            EW_Light <= ew_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        ten_nxt   = Ten_Data;
        one_nxt   = One_Data;
        ns_nxt    = LAMP_G;
        ew_nxt    = LAMP_R;

        if (Tick_1s) begin
            if (Ten_Data == 4'd0 && One_Data == 4'd1) begin
                case (state)
                    NS_GREEN:  state_nxt = NS_YELLOW;
                    NS_YELLOW: state_nxt = EW_GREEN;
                    EW_GREEN:  state_nxt = EW_YELLOW;
                    default:   state_nxt = NS_GREEN;
                endcase
                // Green phases sit on even encodings, yellow phases on odd ones.
                ten_nxt = state_nxt[0] ? Y_TEN : G_TEN;
                one_nxt = state_nxt[0] ? Y_ONE : G_ONE;
            end else if (One_Data == 4'd0) begin
                one_nxt = 4'd9;
                ten_nxt = Ten_Data - 4'd1;
            end else begin
                one_nxt = One_Data - 4'd1;
            end
        end

        // Lamps are decoded from the next state so they switch with the digits.
        case (state_nxt)
            NS_GREEN:  begin ns_nxt = LAMP_G; ew_nxt = LAMP_R; end
            NS_YELLOW: begin ns_nxt = LAMP_Y; ew_nxt = LAMP_R; end
            EW_GREEN:  begin ns_nxt = LAMP_R; ew_nxt = LAMP_G; end
            default:   begin ns_nxt = LAMP_R; ew_nxt = LAMP_Y; end
        endcase
    end

endmodule

// File: tb/tb_traffic_countdown_module.sv
// Randomised-pause bench for traffic_countdown_module: two instances (12/3 s and 99/1 s)
// are checked every cycle against a seconds-level phase model through a scoreboard queue.
module tb_traffic_countdown_module;

    localparam int CNT = 4;

    typedef struct packed {
        logic [3:0] ten;
        logic [3:0] one;
        logic [2:0] ns;
        logic [2:0] ew;
        logic       tick;
    } exp_t;

    logic       clk = 1'b0;
    logic       RSTn;
    logic       Pause;
    logic [3:0] a_ten, a_one, b_ten, b_one;
    logic [2:0] a_ns, a_ew, b_ns, b_ew;
    logic       a_tick, b_tick;

    int checks   = 0;
    int failures = 0;

    exp_t qa[$];
    exp_t qb[$];

    // Behavioural model: phase index, remaining whole seconds, position within the second.
    int       green_s[2]  = '{12, 99};
    int       yellow_s[2] = '{3, 1};
    logic [2:0] ns_tab[4] = '{3'b001, 3'b010, 3'b100, 3'b100};
    logic [2:0] ew_tab[4] = '{3'b100, 3'b100, 3'b001, 3'b010};
    int       ph[2];
    int       rem[2];
    int       pos[2];
    bit       tk[2];

    traffic_countdown_module #(.CNT_1S(CNT), .GREEN_TIME(12), .YELLOW_TIME(3)) dut_a (
        .CLK(clk), .RSTn(RSTn), .Pause(Pause),
        .Ten_Data(a_ten), .One_Data(a_one),
        .NS_Light(a_ns), .EW_Light(a_ew), .Tick_1s(a_tick)
    );

    traffic_countdown_module #(.CNT_1S(CNT), .GREEN_TIME(99), .YELLOW_TIME(1)) dut_b (
        .CLK(clk), .RSTn(RSTn), .Pause(Pause),
        .Ten_Data(b_ten), .One_Data(b_one),
        .NS_Light(b_ns), .EW_Light(b_ew), .Tick_1s(b_tick)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic int phase_len(input int d, input int p);
        return (p % 2 == 0) ? green_s[d] : yellow_s[d];
    endfunction

    task automatic model_reset(input int d);
        ph[d]  = 0;
        rem[d] = green_s[d];
        pos[d] = 0;
        tk[d]  = 1'b0;
    endtask

    task automatic model_edge(input int d, input logic pz, input logic rstn);
        if (!rstn) begin
            model_reset(d);
        end else begin
            if (tk[d]) begin
                if (rem[d] == 1) begin
                    ph[d]  = (ph[d] + 1) % 4;
                    rem[d] = phase_len(d, ph[d]);
                end else begin
                    rem[d] = rem[d] - 1;
                end
            end
            if (pz) begin
                tk[d] = 1'b0;
            end else begin
                tk[d]  = (pos[d] == CNT - 1);
                pos[d] = (pos[d] + 1) % CNT;
            end
        end
    endtask

    function automatic exp_t expect_of(input int d);
        exp_t e;
        e.ten  = 4'(rem[d] / 10);
        e.one  = 4'(rem[d] % 10);
        e.ns   = ns_tab[ph[d]];
        e.ew   = ew_tab[ph[d]];
        e.tick = tk[d];
        return e;
    endfunction

    task automatic compare(input string who, input exp_t e, input logic [3:0] ten, input logic [3:0] one,
                           input logic [2:0] ns, input logic [2:0] ew, input logic tick);
        chk({who, "_ten"}, ten, e.ten);
        chk({who, "_one"}, one, e.one);
        chk({who, "_ns"}, ns, e.ns);
        chk({who, "_ew"}, ew, e.ew);
        chk({who, "_tick"}, tick, e.tick);
        chk({who, "_one_dir_red"}, int'(ns == 3'b100 || ew == 3'b100), 1);
        chk({who, "_digits_bcd"}, int'(ten <= 4'd9 && one <= 4'd9), 1);
        chk({who, "_digits_nonzero"}, int'(ten != 4'd0 || one != 4'd0), 1);
    endtask

    // Monitor: one expectation per clock edge, compared on the falling edge.
    always @(negedge clk) begin
        exp_t e;
        if (qa.size() > 0) begin
            e = qa.pop_front();
            compare("a", e, a_ten, a_one, a_ns, a_ew, a_tick);
        end
        if (qb.size() > 0) begin
            e = qb.pop_front();
            compare("b", e, b_ten, b_one, b_ns, b_ew, b_tick);
        end
    end

    task automatic step(input logic pz, input bit arst);
        logic rs;
        Pause = pz;
        @(posedge clk);
        rs = RSTn;
        model_edge(0, pz, rs);
        model_edge(1, pz, rs);
        #1;
        if (arst) begin
            #2;
            RSTn = 1'b0;
            model_reset(0);
            model_reset(1);
            #1;
            chk("arst_a_ten", a_ten, 1);
            chk("arst_a_one", a_one, 2);
            chk("arst_a_ns", a_ns, 3'b001);
            chk("arst_a_ew", a_ew, 3'b100);
            chk("arst_a_tick", a_tick, 0);
            chk("arst_b_ten", b_ten, 9);
            chk("arst_b_one", b_one, 9);
        end
        qa.push_back(expect_of(0));
        qb.push_back(expect_of(1));
    endtask

    task automatic run_random(input int n);
        for (int i = 0; i < n; i++) begin
            step(logic'($urandom_range(0, 15) == 0), 1'b0);
        end
    endtask

    initial begin
        RSTn  = 1'b0;
        Pause = 1'b0;
        model_reset(0);
        model_reset(1);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0);
        RSTn = 1'b1;

        // Clean first cycle: ticks on every 4th edge, borrow and phase changes.
        for (int i = 0; i < 130; i++) step(1'b0, 1'b0);

        // Freeze mid-second with the prescaler at 2.
        for (int i = 0; i < 8 && pos[0] != 2; i++) step(1'b0, 1'b0);
        chk("pause_setup_pos", pos[0], 2);
        for (int i = 0; i < 20; i++) step(1'b1, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0);

        run_random(320);

        // Asynchronous reset in the middle of the EW yellow phase of instance a.
        for (int i = 0; i < 400 && ph[0] != 3; i++) step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        chk("a_in_ew_yellow", a_ew, 3'b010);
        step(1'b0, 1'b1);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        RSTn = 1'b1;
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0);

        run_random(500);

        @(negedge clk);
        #1;
        chk("scoreboard_drained", qa.size() + qb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
